uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 82 ++++++++
 tb/tb_uart_tx_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin byte arbiter feeding one UART transmitter; define UART_TX_ARB_PACKET_LOCK_EN to enable packet locking
module uart_tx_arbiter #(
  parameter int NumRequesters = 4,
  parameter int DataWidth = 8
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic [NumRequesters-1:0]           req_valid_i,
  input  logic [NumRequesters*DataWidth-1:0] req_data_i,
  input  logic [NumRequesters-1:0]           req_last_i,
  output logic [NumRequesters-1:0]           req_ready_o,
  output logic [DataWidth-1:0]               uart_data_o,
  output logic                               uart_start_o,
  input  logic                               uart_ready_i,
  output logic [NumRequesters-1:0]           grant_o,
  output logic                               busy_o
);
  localparam int PW = $clog2(NumRequesters);
  typedef enum logic [1:0] {IDLE, START, GUARD, WAIT_DONE} state_t;
  state_t r_state, w_next;
  logic [PW-1:0] r_ptr, w_win, w_idx, w_ptr_next;
  logic [NumRequesters-1:0] r_grant, w_elig, w_win_oh;
  logic [DataWidth-1:0] r_data;
  logic w_accept, w_held;
`ifdef UART_TX_ARB_PACKET_LOCK_EN
  logic r_locked;
  assign w_elig = r_locked ? (req_valid_i & r_grant) : req_valid_i;
  assign w_held = r_locked;
  // a non-last byte locks the owner in; its last byte releases the lock
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) r_locked <= 1'b0;
    else if (w_accept) r_locked <= !req_last_i[w_win];
`else
  logic w_unused_last;
  assign w_unused_last = ^req_last_i;
  assign w_elig = req_valid_i;
  assign w_held = 1'b0;
`endif
  assign w_accept = !reset_i && r_state == IDLE && uart_ready_i && |w_elig;
  // round-robin search from r_ptr; the smallest offset with an eligible valid wins
  always_comb begin
    w_win = '0;
    w_idx = '0;
    for (int k = NumRequesters - 1; k >= 0; k--) begin
      w_idx = PW'((int'(r_ptr) + k) % NumRequesters);
      if (w_elig[w_idx]) w_win = w_idx;
    end
  end
  assign w_ptr_next = (w_win == PW'(NumRequesters - 1)) ? '0 : w_win + 1'b1;
  assign w_win_oh = {{(NumRequesters-1){1'b0}}, 1'b1} << w_win;
  // next state: START and GUARD last one cycle each; WAIT_DONE leaves once the transmitter is idle
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      w_next = w_accept ? START : IDLE;
      START:     w_next = GUARD;
      GUARD:     w_next = WAIT_DONE;
      WAIT_DONE: w_next = uart_ready_i ? IDLE : WAIT_DONE;
      default:   w_next = IDLE;
    endcase
  end
  // state register plus owner, pointer and byte captured on accept
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      r_state <= IDLE;
      r_ptr <= '0;
      r_grant <= '0;
      r_data <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_ptr <= w_ptr_next;
        r_grant <= w_win_oh;
        r_data <= req_data_i[w_win*DataWidth +: DataWidth];
      end
    end
  assign req_ready_o = w_accept ? w_win_oh : '0;
  assign uart_data_o = r_data;
  assign uart_start_o = r_state == START;
  assign busy_o = r_state != IDLE;
  assign grant_o = (busy_o || w_held) ? r_grant : '0;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized checks of uart_tx_arbiter against a cycle-timeline reference model
module tb_uart_tx_arbiter;
  localparam int N = 4, DW = 8;
`ifdef UART_TX_ARB_PACKET_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif
  logic clk = 1'b0, reset_i;
  logic [N-1:0] req_valid_i, req_last_i, req_ready_o, grant_o;
  logic [N*DW-1:0] req_data_i;
  logic [DW-1:0] uart_data_o;
  logic uart_start_o, uart_ready_i, busy_o;
  always #5 clk = ~clk;
  uart_tx_arbiter #(.NumRequesters(N), .DataWidth(DW)) dut (
    .clk_i(clk), .reset_i(reset_i), .req_valid_i(req_valid_i), .req_data_i(req_data_i),
    .req_last_i(req_last_i), .req_ready_o(req_ready_o), .uart_data_o(uart_data_o),
    .uart_start_o(uart_start_o), .uart_ready_i(uart_ready_i), .grant_o(grant_o), .busy_o(busy_o)
  );
  int errors = 0, checks = 0;
  int cyc, acc_c, done_c, ptr, owner;
  bit locked;
  logic [DW-1:0] m_data;
  int served[$];
  bit pend[N];
  logic [DW-1:0] pdata[N];
  bit plast[N];
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      int i = (ptr + k) % N;
      if (req_valid_i[i] && (!locked || i == owner)) return i;
    end
    return -1;
  endfunction
  function automatic void model_reset();
    cyc = 0; acc_c = -100; done_c = -100; ptr = 0; owner = 0; locked = 0; m_data = '0;
    served.delete();
  endfunction
  task automatic step();
    int w;
    bit idle;
    #1;
    idle = cyc <= acc_c || cyc > done_c;
    w = (idle && uart_ready_i) ? pick() : -1;
    check("req_ready", 32'(req_ready_o), w >= 0 ? 32'(1 << w) : 32'd0);
    check("uart_start", 32'(uart_start_o), 32'(cyc == acc_c + 1));
    check("busy", 32'(busy_o), 32'(!idle));
    check("uart_data", 32'(uart_data_o), 32'(m_data));
    check("grant", 32'(grant_o), (!idle || locked) ? 32'(1 << owner) : 32'd0);
    @(posedge clk);
    if (!idle && cyc >= acc_c + 3 && uart_ready_i) done_c = cyc;
    if (w >= 0) begin
      acc_c = cyc; done_c = 1 << 30; owner = w; ptr = (w + 1) % N;
      m_data = req_data_i[w*DW +: DW];
      locked = LOCK && !req_last_i[w];
      served.push_back(w);
    end
    cyc++;
    #1;
  endtask
  task automatic do_reset();
    reset_i = 1'b1;
    req_valid_i = '0; req_last_i = '1; req_data_i = '0; uart_ready_i = 1'b1;
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    model_reset();
  endtask
  task automatic check_zero(string tag);
    check({tag, "_ready"}, 32'(req_ready_o), 0);
    check({tag, "_start"}, 32'(uart_start_o), 0);
    check({tag, "_data"}, 32'(uart_data_o), 0);
    check({tag, "_grant"}, 32'(grant_o), 0);
    check({tag, "_busy"}, 32'(busy_o), 0);
  endtask
  initial begin
    int sz, k2;
    int exp_lock[6] = '{1, 2, 2, 2, 0, 0};
    int exp_rr[6] = '{1, 2, 0, 2, 0, 2};
    reset_i = 1'b1;
    req_valid_i = '1; req_last_i = '1; req_data_i = '1; uart_ready_i = 1'b1;
    @(posedge clk);
    #1;
    check_zero("reset");
    reset_i = 1'b0;
    model_reset();
    // single byte
    req_valid_i = 4'b0001; req_data_i = '0; req_data_i[7:0] = 8'h41;
    step();
    req_valid_i = '0;
    step(); step();
    uart_ready_i = 1'b0;
    for (int i = 0; i < 10; i++) step();
    uart_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("single_data", 32'(uart_data_o), 32'h41);
    check("single_served", 32'(served.size()), 1);
    // fairness
    do_reset();
    req_valid_i = '1;
    for (int i = 0; i < N; i++) req_data_i[i*DW +: DW] = 8'h10 + 8'(i);
    for (int i = 0; i < 20; i++) step();
    for (int i = 0; i < 5; i++) check("fair_order", 32'(served.size() > i ? served[i] : 99), 32'(i % N));
    // transmitter not ready
    do_reset();
    req_valid_i = 4'b0010; uart_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("notready_none", 32'(served.size()), 0);
    uart_ready_i = 1'b1;
    step();
    check("notready_accept", 32'(served.size() > 0 ? served[0] : 99), 1);
    // packet lock versus per-byte arbitration
    do_reset();
    req_valid_i = 4'b0010;
    step();
    k2 = 0;
    for (int n = 0; n < 100 && served.size() < 6; n++) begin
      req_valid_i = {1'b0, k2 < 3, 1'b0, 1'b1};
      req_data_i[0 +: DW] = 8'hA0;
      req_data_i[2*DW +: DW] = 8'hC0 + 8'(k2);
      req_last_i = {1'b1, k2 == 2, 1'b1, 1'b1};
      sz = served.size();
      step();
      if (served.size() != sz && served[$] == 2) k2++;
    end
    for (int i = 0; i < 6; i++)
      check("pkt_order", 32'(served.size() > i ? served[i] : 99), 32'(LOCK ? exp_lock[i] : exp_rr[i]));
    // reset during WAIT_DONE
    do_reset();
    req_valid_i = 4'b0001; req_data_i[7:0] = 8'h5A;
    step();
    uart_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) step();
    reset_i = 1'b1; req_valid_i = '1; uart_ready_i = 1'b1;
    #1;
    check_zero("midreset");
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    model_reset();
    step();
    check("midreset_first", 32'(served.size() > 0 ? served[0] : 99), 0);
    // randomized traffic
    do_reset();
    for (int i = 0; i < N; i++) pend[i] = 0;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1; pdata[i] = 8'($urandom); plast[i] = $urandom_range(0, 2) == 0;
        end
        req_valid_i[i] = pend[i] && $urandom_range(0, 9) != 0;
        req_data_i[i*DW +: DW] = pdata[i];
        req_last_i[i] = plast[i];
      end
      uart_ready_i = $urandom_range(0, 3) != 0;
      sz = served.size();
      step();
      if (served.size() != sz) pend[served[$]] = 0;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
